// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
//
// Registered WISC instruction-decode stage feeding the execute-stage ALU.
// A 16-bit instruction accepted from fetch is decoded into the ALU control
// bundle (Op, operand inversion, carry-in, signedness, operand selects and
// write-back/halt/illegal flags) and presented to execute one cycle later.
// An output register plus one skid register keep full throughput under
// execute back-pressure while preserving strict FIFO order.
//
// Configuration:
//   ALU_DEC_ILLEGAL_EN  when defined, unmapped opcodes (00010, 00011) raise
//                       `illegal`; otherwise `illegal` is tied to 0. Either
//                       way such opcodes decode as NOP.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   fetch presents an instruction
//   in_ready   stage can accept (depends on registered state only)
//   in_instr   instruction; opcode = [15:11], func = [1:0]
//   flush      discard all held and incoming instructions on the next edge
//   out_valid  decoded bundle valid
//   out_ready  execute accepts the bundle
//   alu_op     ALU operation code
//   inv_a      invert A operand
//   inv_b      invert B operand
//   cin        ALU carry-in
//   sign       signed arithmetic (overflow semantics)
//   b_sel      B operand: 0 Rt, 1 simm5, 2 zimm5, 3 simm8, 4 zimm8, 5 zero
//   a_zero     force A operand to zero
//   reg_write  result is written back
//   halt       bundle is HALT
//   illegal    bundle came from an unmapped opcode
// ---------------------------------------------------------------------------
module alu_ctrl_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic        inv_a,
    output logic        inv_b,
    output logic        cin,
    output logic        sign,
    output logic [2:0]  b_sel,
    output logic        a_zero,
    output logic        reg_write,
    output logic        halt,
    output logic        illegal
);

    // -----------------------------------------------------------------------
    // Encodings
    // -----------------------------------------------------------------------
    localparam logic [4:0] OPC_HALT  = 5'b00000;
    localparam logic [4:0] OPC_NOP   = 5'b00001;
    localparam logic [4:0] OPC_J     = 5'b00100;
    localparam logic [4:0] OPC_JR    = 5'b00101;
    localparam logic [4:0] OPC_JAL   = 5'b00110;
    localparam logic [4:0] OPC_JALR  = 5'b00111;
    localparam logic [4:0] OPC_ADDI  = 5'b01000;
    localparam logic [4:0] OPC_SUBI  = 5'b01001;
    localparam logic [4:0] OPC_XORI  = 5'b01010;
    localparam logic [4:0] OPC_ANDNI = 5'b01011;
    localparam logic [4:0] OPC_BEQZ  = 5'b01100;
    localparam logic [4:0] OPC_BNEZ  = 5'b01101;
    localparam logic [4:0] OPC_BLTZ  = 5'b01110;
    localparam logic [4:0] OPC_BGEZ  = 5'b01111;
    localparam logic [4:0] OPC_ST    = 5'b10000;
    localparam logic [4:0] OPC_LD    = 5'b10001;
    localparam logic [4:0] OPC_SLBI  = 5'b10010;
    localparam logic [4:0] OPC_STU   = 5'b10011;
    localparam logic [4:0] OPC_ROLI  = 5'b10100;
    localparam logic [4:0] OPC_SLLI  = 5'b10101;
    localparam logic [4:0] OPC_RORI  = 5'b10110;
    localparam logic [4:0] OPC_SRLI  = 5'b10111;
    localparam logic [4:0] OPC_LBI   = 5'b11000;
    localparam logic [4:0] OPC_BTR   = 5'b11001;
    localparam logic [4:0] OPC_SHFT  = 5'b11010;  // ROL/SLL/ROR/SRL by func
    localparam logic [4:0] OPC_ARTH  = 5'b11011;  // ADD/SUB/XOR/ANDN by func
    localparam logic [4:0] OPC_SEQ   = 5'b11100;
    localparam logic [4:0] OPC_SLT   = 5'b11101;
    localparam logic [4:0] OPC_SLE   = 5'b11110;
    localparam logic [4:0] OPC_SCO   = 5'b11111;

    localparam logic [4:0] ALU_ROL  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SRL  = 5'b00011;
    localparam logic [4:0] ALU_ADD  = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_ANDN = 5'b00111;
    localparam logic [4:0] ALU_ROR  = 5'b01000;
    localparam logic [4:0] ALU_BTR  = 5'b01001;
    localparam logic [4:0] ALU_EQ   = 5'b01010;  // SEQ and BEQZ
    localparam logic [4:0] ALU_LT   = 5'b01011;  // SLT and BLTZ
    localparam logic [4:0] ALU_LE   = 5'b01100;
    localparam logic [4:0] ALU_CO   = 5'b01101;
    localparam logic [4:0] ALU_NE   = 5'b01110;
    localparam logic [4:0] ALU_GE   = 5'b01111;
    localparam logic [4:0] ALU_SLBI = 5'b10000;

    localparam logic [2:0] BSEL_RT    = 3'd0;
    localparam logic [2:0] BSEL_SIMM5 = 3'd1;
    localparam logic [2:0] BSEL_ZIMM5 = 3'd2;
    localparam logic [2:0] BSEL_SIMM8 = 3'd3;
    localparam logic [2:0] BSEL_ZIMM8 = 3'd4;
    localparam logic [2:0] BSEL_ZERO  = 3'd5;

`ifdef ALU_DEC_ILLEGAL_EN
    localparam logic ILLEGAL_FLAG = 1'b1;
`else
    localparam logic ILLEGAL_FLAG = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] alu_op;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       sign;
        logic [2:0] b_sel;
        logic       a_zero;
        logic       reg_write;
        logic       halt;
        logic       illegal;
    } bundle_t;

    // NOP bundle: plain add, no modifiers, no write-back.
    localparam bundle_t NOP_BUNDLE = '{
        alu_op: ALU_ADD, inv_a: 1'b0, inv_b: 1'b0, cin: 1'b0, sign: 1'b0,
        b_sel: BSEL_RT, a_zero: 1'b0, reg_write: 1'b0, halt: 1'b0,
        illegal: 1'b0
    };

    // -----------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // -----------------------------------------------------------------------
    logic [4:0] opcode;
    logic [1:0] func;
    bundle_t    dec;
    logic       unused_instr_bits;

    assign opcode            = in_instr[15:11];
    assign func              = in_instr[1:0];
    assign unused_instr_bits = ^in_instr[10:2];

    always_comb begin
        // NOTE: every field gets a default before the case so no path can
        // leave a field unassigned and infer a latch.
        dec = NOP_BUNDLE;
        case (opcode)
            OPC_HALT:  dec.halt = 1'b1;
            OPC_NOP:   ;
            OPC_J:     ;
            OPC_JR:    dec.b_sel = BSEL_SIMM8;
            OPC_JAL:   dec.reg_write = 1'b1;
            OPC_JALR: begin
                dec.b_sel     = BSEL_SIMM8;
                dec.reg_write = 1'b1;
            end
            OPC_ADDI: begin
                dec.sign      = 1'b1;
                dec.b_sel     = BSEL_SIMM5;
                dec.reg_write = 1'b1;
            end
            // Subtract computes Rt - Rs: invert A and add one.
            OPC_SUBI: begin
                dec.inv_a     = 1'b1;
                dec.cin       = 1'b1;
                dec.sign      = 1'b1;
                dec.b_sel     = BSEL_SIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_XORI: begin
                dec.alu_op    = ALU_XOR;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_ANDNI: begin
                dec.alu_op    = ALU_ANDN;
                dec.inv_b     = 1'b1;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            // Branches test Rs against zero.
            OPC_BEQZ: begin
                dec.alu_op = ALU_EQ;
                dec.b_sel  = BSEL_ZERO;
            end
            OPC_BNEZ: begin
                dec.alu_op = ALU_NE;
                dec.b_sel  = BSEL_ZERO;
            end
            OPC_BLTZ: begin
                dec.alu_op = ALU_LT;
                dec.b_sel  = BSEL_ZERO;
            end
            OPC_BGEZ: begin
                dec.alu_op = ALU_GE;
                dec.b_sel  = BSEL_ZERO;
            end
            OPC_ST:    dec.b_sel = BSEL_SIMM5;
            OPC_LD: begin
                dec.b_sel     = BSEL_SIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_SLBI: begin
                dec.alu_op    = ALU_SLBI;
                dec.b_sel     = BSEL_ZIMM8;
                dec.reg_write = 1'b1;
            end
            // STU writes the updated base address back to Rs.
            OPC_STU: begin
                dec.b_sel     = BSEL_SIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_ROLI: begin
                dec.alu_op    = ALU_ROL;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_SLLI: begin
                dec.alu_op    = ALU_SLL;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_RORI: begin
                dec.alu_op    = ALU_ROR;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            OPC_SRLI: begin
                dec.alu_op    = ALU_SRL;
                dec.b_sel     = BSEL_ZIMM5;
                dec.reg_write = 1'b1;
            end
            // LBI is 0 + simm8.
            OPC_LBI: begin
                dec.a_zero    = 1'b1;
                dec.b_sel     = BSEL_SIMM8;
                dec.reg_write = 1'b1;
            end
            OPC_BTR: begin
                dec.alu_op    = ALU_BTR;
                dec.reg_write = 1'b1;
            end
            OPC_SHFT: begin
                dec.reg_write = 1'b1;
                case (func)
                    2'b00: dec.alu_op = ALU_ROL;
                    2'b01: dec.alu_op = ALU_SLL;
                    2'b10: dec.alu_op = ALU_ROR;
                    2'b11: dec.alu_op = ALU_SRL;
                endcase
            end
            OPC_ARTH: begin
                dec.reg_write = 1'b1;
                case (func)
                    2'b00: dec.sign = 1'b1;
                    2'b01: begin
                        dec.inv_a = 1'b1;
                        dec.cin   = 1'b1;
                        dec.sign  = 1'b1;
                    end
                    2'b10: dec.alu_op = ALU_XOR;
                    2'b11: begin
                        dec.alu_op = ALU_ANDN;
                        dec.inv_b  = 1'b1;
                    end
                endcase
            end
            OPC_SEQ: begin
                dec.alu_op    = ALU_EQ;
                dec.reg_write = 1'b1;
            end
            // Set-less compares compute Rs - Rt: invert B and add one.
            OPC_SLT: begin
                dec.alu_op    = ALU_LT;
                dec.inv_b     = 1'b1;
                dec.cin       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_SLE: begin
                dec.alu_op    = ALU_LE;
                dec.inv_b     = 1'b1;
                dec.cin       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_SCO: begin
                dec.alu_op    = ALU_CO;
                dec.reg_write = 1'b1;
            end
            // Unmapped opcodes execute as NOP.
            default:   dec.illegal = ILLEGAL_FLAG;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register + skid register
    // -----------------------------------------------------------------------
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;
    logic    halted_q;
    logic    in_fire;
    logic    out_free;

    // A full skid register or a latched HALT closes the input.
    assign in_ready = !skid_valid_q && !halted_q;
    assign in_fire  = in_valid && in_ready;
    // The output register can take new contents this edge.
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst || flush) begin
            // NOTE: bundle storage is reset too, so outputs read as zero
            // rather than stale or X data while out_valid is low.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            if (out_free) begin
                // Older skid entry has priority; in_ready is low whenever
                // the skid is occupied, so no input can be lost here.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (in_fire) begin
                    out_q       <= dec;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (in_fire) begin
                // Output stalled: park the new bundle behind it.
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end

            if (in_fire && dec.halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = out_q.alu_op;
    assign inv_a     = out_q.inv_a;
    assign inv_b     = out_q.inv_b;
    assign cin       = out_q.cin;
    assign sign      = out_q.sign;
    assign b_sel     = out_q.b_sel;
    assign a_zero    = out_q.a_zero;
    assign reg_write = out_q.reg_write;
    assign halt      = out_q.halt;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_decode
//
// Self-checking bench for alu_ctrl_decode. A reference model classifies each
// instruction into a mnemonic and derives the expected bundle from per-field
// rules; a FIFO scoreboard tracks instructions held by the stage. Directed
// scenarios cover reset, decode examples, back-pressure, flush, HALT and
// unmapped opcodes, followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic        inv_a, inv_b, cin, sign;
    logic [2:0]  b_sel;
    logic        a_zero, reg_write, halt, illegal;

    alu_ctrl_decode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .inv_a     (inv_a),
        .inv_b     (inv_b),
        .cin       (cin),
        .sign      (sign),
        .b_sel     (b_sel),
        .a_zero    (a_zero),
        .reg_write (reg_write),
        .halt      (halt),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

`ifdef ALU_DEC_ILLEGAL_EN
    localparam bit ILL_EXP = 1'b1;
`else
    localparam bit ILL_EXP = 1'b0;
`endif

    typedef enum {
        M_HALT, M_NOP, M_J, M_JR, M_JAL, M_JALR, M_ADDI, M_SUBI, M_XORI,
        M_ANDNI, M_BEQZ, M_BNEZ, M_BLTZ, M_BGEZ, M_ST, M_LD, M_SLBI, M_STU,
        M_ROLI, M_SLLI, M_RORI, M_SRLI, M_LBI, M_BTR, M_ROL, M_SLL, M_ROR,
        M_SRL, M_ADD, M_SUB, M_XOR, M_ANDN, M_SEQ, M_SLT, M_SLE, M_SCO, M_ILL
    } mnem_t;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       sign;
        logic [2:0] b_sel;
        logic       a_zero;
        logic       reg_write;
        logic       halt;
        logic       illegal;
    } bundle_t;

    int      errors = 0;
    int      checks = 0;
    bundle_t q[$];
    bit      halted_m = 1'b0;
    bit      last_in_fire = 1'b0;
    int      dut_fires = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic mnem_t classify(input logic [15:0] i);
        logic [1:0] f;
        f = i[1:0];
        case (i[15:11])
            5'b00000: return M_HALT;
            5'b00001: return M_NOP;
            5'b00100: return M_J;
            5'b00101: return M_JR;
            5'b00110: return M_JAL;
            5'b00111: return M_JALR;
            5'b01000: return M_ADDI;
            5'b01001: return M_SUBI;
            5'b01010: return M_XORI;
            5'b01011: return M_ANDNI;
            5'b01100: return M_BEQZ;
            5'b01101: return M_BNEZ;
            5'b01110: return M_BLTZ;
            5'b01111: return M_BGEZ;
            5'b10000: return M_ST;
            5'b10001: return M_LD;
            5'b10010: return M_SLBI;
            5'b10011: return M_STU;
            5'b10100: return M_ROLI;
            5'b10101: return M_SLLI;
            5'b10110: return M_RORI;
            5'b10111: return M_SRLI;
            5'b11000: return M_LBI;
            5'b11001: return M_BTR;
            5'b11010: return (f == 2'd0) ? M_ROL : (f == 2'd1) ? M_SLL :
                             (f == 2'd2) ? M_ROR : M_SRL;
            5'b11011: return (f == 2'd0) ? M_ADD : (f == 2'd1) ? M_SUB :
                             (f == 2'd2) ? M_XOR : M_ANDN;
            5'b11100: return M_SEQ;
            5'b11101: return M_SLT;
            5'b11110: return M_SLE;
            5'b11111: return M_SCO;
            default:  return M_ILL;
        endcase
    endfunction

    // Expected bundle derived field by field from the mnemonic.
    function automatic bundle_t model(input logic [15:0] i);
        mnem_t   m;
        bundle_t b;
        m = classify(i);
        b = '0;
        case (m)
            M_XOR, M_XORI:                     b.alu_op = 5'b00110;
            M_ANDN, M_ANDNI:                   b.alu_op = 5'b00111;
            M_ROL, M_ROLI:                     b.alu_op = 5'b00000;
            M_SLL, M_SLLI:                     b.alu_op = 5'b00001;
            M_ROR, M_RORI:                     b.alu_op = 5'b01000;
            M_SRL, M_SRLI:                     b.alu_op = 5'b00011;
            M_SEQ, M_BEQZ:                     b.alu_op = 5'b01010;
            M_SLT, M_BLTZ:                     b.alu_op = 5'b01011;
            M_SLE:                             b.alu_op = 5'b01100;
            M_SCO:                             b.alu_op = 5'b01101;
            M_BNEZ:                            b.alu_op = 5'b01110;
            M_BGEZ:                            b.alu_op = 5'b01111;
            M_BTR:                             b.alu_op = 5'b01001;
            M_SLBI:                            b.alu_op = 5'b10000;
            default:                           b.alu_op = 5'b00100;
        endcase
        b.inv_a = (m inside {M_SUB, M_SUBI});
        b.inv_b = (m inside {M_ANDN, M_ANDNI, M_SLT, M_SLE});
        b.cin   = (m inside {M_SUB, M_SUBI, M_SLT, M_SLE});
        b.sign  = (m inside {M_ADD, M_ADDI, M_SUB, M_SUBI});
        if (m inside {M_ADDI, M_SUBI, M_LD, M_ST, M_STU})
            b.b_sel = 3'd1;
        else if (m inside {M_XORI, M_ANDNI, M_ROLI, M_SLLI, M_RORI, M_SRLI})
            b.b_sel = 3'd2;
        else if (m inside {M_JR, M_JALR, M_LBI})
            b.b_sel = 3'd3;
        else if (m == M_SLBI)
            b.b_sel = 3'd4;
        else if (m inside {M_BEQZ, M_BNEZ, M_BLTZ, M_BGEZ})
            b.b_sel = 3'd5;
        b.a_zero    = (m == M_LBI);
        b.reg_write = !(m inside {M_ST, M_BEQZ, M_BNEZ, M_BLTZ, M_BGEZ, M_J,
                                  M_JR, M_NOP, M_HALT, M_ILL});
        b.halt      = (m == M_HALT);
        b.illegal   = ILL_EXP && (m == M_ILL);
        return b;
    endfunction

    // One clock: compare at the falling edge, advance the model, then
    // return 1 time unit after the rising edge so the caller can drive.
    task automatic tick();
        bit exp_ready;
        bundle_t e;
        @(negedge clk);
        exp_ready = (q.size() < 2) && !halted_m;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            e = q[0];
            check("alu_op", alu_op, e.alu_op);
            check("inv_a/inv_b/cin/sign", {inv_a, inv_b, cin, sign},
                  {e.inv_a, e.inv_b, e.cin, e.sign});
            check("b_sel", b_sel, e.b_sel);
            check("a_zero/reg_write/halt/illegal",
                  {a_zero, reg_write, halt, illegal},
                  {e.a_zero, e.reg_write, e.halt, e.illegal});
        end
        if (out_valid === 1'b1 && out_ready) dut_fires++;
        last_in_fire = 1'b0;
        if (rst || flush) begin
            q.delete();
            halted_m = 1'b0;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                q.push_back(model(in_instr));
                last_in_fire = 1'b1;
                if (classify(in_instr) == M_HALT) halted_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst alu_op", alu_op, 0);
        check("rst b_sel", b_sel, 0);
        check("rst flags", {inv_a, inv_b, cin, sign, a_zero, reg_write, halt, illegal}, 0);

        // ADD, one-cycle latency
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 16'hD800;
        tick();
        check("add out_valid", out_valid, 1);
        check("add alu_op", alu_op, 5'b00100);
        check("add inv_a/cin/sign/rw", {inv_a, cin, sign, reg_write}, 4'b0011);

        // SUBI then SLT
        in_instr = 16'h4BE5;
        tick();
        check("subi alu_op", alu_op, 5'b00100);
        check("subi inv_a/cin/b_sel", {inv_a, cin, b_sel}, {2'b11, 3'd1});
        in_instr = 16'hE800;
        tick();
        check("slt alu_op", alu_op, 5'b01011);
        check("slt inv_b/cin", {inv_b, cin}, 2'b11);

        // Back-pressure: 3 instructions, skid fills after the 2nd
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; dut_fires = 0;
        in_instr = 16'h4001;
        tick();
        in_instr = 16'h5002;
        tick();
        check("bp in_ready low", in_ready, 0);
        in_instr = 16'hD801;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6 && !last_in_fire; i++) tick();
        check("bp third accepted", last_in_fire, 1);
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp transfers", dut_fires, 3);

        // Flush with skid full and a concurrent input
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 16'h4004;
        tick();
        in_instr = 16'h4005;
        tick();
        in_instr = 16'h4006; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        in_valid = 1'b0; out_ready = 1'b1; dut_fires = 0;
        repeat (3) tick();
        check("flush no output", dut_fires, 0);

        // HALT latches and closes the input until reset
        in_valid = 1'b1; in_instr = 16'h0000;
        tick();
        check("halt flag", {out_valid, halt}, 2'b11);
        check("halt in_ready", in_ready, 0);
        in_instr = 16'hD800;
        repeat (3) tick();
        check("halt in_ready held", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt rst in_ready", in_ready, 1);

        // Unmapped opcodes
        in_instr = 16'h1000;
        tick();
        check("ill illegal", illegal, ILL_EXP);
        check("ill alu_op", alu_op, 5'b00100);
        check("ill reg_write", reg_write, 0);
        in_instr = 16'h1803;
        tick();

        // Reset and flush together with skid full
        out_ready = 1'b0; in_instr = 16'hA000;
        repeat (2) tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check("rst+flush out_valid", out_valid, 0);
        check("rst+flush in_ready", in_ready, 1);
        check("rst+flush alu_op", alu_op, 0);

        // Randomized stream
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 3);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 65);
            in_instr  = 16'($urandom);
            if (in_instr[15:11] == 5'b00000 && $urandom_range(0, 3) != 0)
                in_instr[15:11] = 5'b11011;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode.md
# alu_ctrl_decode

Registered instruction-decode stage that converts a 16-bit WISC instruction into the control bundle consumed by the execute-stage `alu`: Op, invA, invB, Cin, sign and operand selects. It sits between fetch and execute and uses valid/ready handshakes on both sides. A 2-entry skid buffer keeps full throughput under execute back-pressure. The stage also supports flush, HALT latching and illegal-opcode flagging.

## Interface
Parameters: none.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  fetch presents instruction
- `in_ready`  out  1  stage accepts; transfer when `in_valid && in_ready`
- `in_instr`  in  16  instruction; opcode = [15:11], func = [1:0]
- `flush`  in  1  discard all held and incoming instructions
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  execute accepts; transfer when `out_valid && out_ready`
- `alu_op`  out  5  ALU Op code
- `inv_a`, `inv_b`, `cin`, `sign`  out  1 each  ALU operand modifiers
- `b_sel`  out  3  B operand: 0 Rt, 1 simm5, 2 zimm5, 3 simm8, 4 zimm8, 5 zero
- `a_zero`  out  1  force A operand to 0 (LBI)
- `reg_write`  out  1  result is written back
- `halt`  out  1  bundle is HALT
- `illegal`  out  1  bundle came from an unmapped opcode

## Operation
- Decode, as alu_op/inv_a/inv_b/cin:
  - ADD/ADDI/LD/ST/STU/J/JAL/JR/JALR: 00100/0/0/0.
  - SUB/SUBI: 00100/1/0/1, computing Rt−Rs.
  - XOR(I): 00110. ANDN(I): 00111 with inv_b=1.
  - ROL(I): 00000. SLL(I): 00001. ROR(I): 01000. SRL(I): 00011.
  - SEQ: 01010. SLT: 01011/0/1/1. SLE: 01100/0/1/1. SCO: 01101.
  - BEQZ: 01010. BNEZ: 01110. BLTZ: 01011. BGEZ: 01111. All four branches use b_sel=5.
  - BTR: 01001. SLBI: 10000 with b_sel=4. LBI: 00100 with a_zero=1 and b_sel=3.
- `sign`=1 only for ADD/ADDI/SUB/SUBI.
- Immediates: ADDI/SUBI/LD/ST/STU use b_sel=1; XORI/ANDNI/shift-immediates use b_sel=2; JR/JALR use b_sel=3.
- `reg_write`=0 for ST, branches, J, JR, NOP, HALT. It is 1 otherwise, including STU, JAL and JALR.
- NOP (00001) and HALT (00000) decode as 00100 with all flags 0. HALT additionally sets `halt`.
- Storage: output register plus one skid register; ordering is strictly FIFO.
- `in_ready = !skid_valid && !halted`.
- Accepting an instruction while the output is valid and not taken loads the skid register. On the next output transfer, the skid contents move to the output register.
- Halted: set in the cycle a HALT is accepted. Once set, `in_ready` is held 0 until `rst`. Instructions already held still drain normally.
- Flush: on the next edge, both registers and `halted` are cleared. An input transfer in the same cycle is discarded.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset: `out_valid`=0, `in_ready`=1, skid empty, halted=0. All bundle outputs reset to 0 (alu_op=00000, b_sel=0).
- Bundle outputs are stable while `out_valid && !out_ready`. `in_ready` is a function of registered state only.
- Simultaneous output transfer and input transfer with skid empty: the output register reloads from the input and the skid stays empty.
- `rst` and `flush` in the same cycle: reset wins, with identical result.
- `rst` mid-stream drops every held instruction.

## Configuration
- `ALU_DEC_ILLEGAL_EN` defined: opcodes 00010, 00011, and any opcode outside the table decode as NOP with `illegal`=1.
- Not defined: the same opcodes decode as NOP, and `illegal` is tied to 0.

## Test plan
- Reset, then ADD (0xD800 func 00) with `out_ready`=1 → next cycle `out_valid`=1, alu_op=00100, inv_a=0, cin=0, sign=1, reg_write=1.
- SUBI (0x4BE5) → alu_op=00100, inv_a=1, cin=1, b_sel=1. Then SLT (0xE800) → alu_op=01011, inv_b=1, cin=1.
- Stream of 3 instructions with `out_ready`=0 from cycle 1 → `in_ready` falls after the 2nd acceptance. Raising `out_ready` yields all 3 in order, with no drop and no duplicate.
- Skid full, then `flush`=1 while `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1; the flushed input never appears.
- HALT (0x0000) accepted → `halt`=1 on the output and `in_ready`=0 thereafter. `rst` restores `in_ready`=1.
- Opcode 00010 with macro defined → `illegal`=1, alu_op=00100, reg_write=0. Without the macro → `illegal`=0.
